// File: rtl/mux_arb_pipe.sv
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking.
// mode=0 picks the channel named by sel. mode=1 scans the requesting channels
// round-robin, starting just after the channel that last transferred.
// A single output register slot can drain and refill on the same edge, so
// throughput is one word per cycle while out_ready stays high.
module mux_arb_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic [SEL_W-1:0]  rr_ptr;
  logic              load_en;
  logic              any_gnt;
  logic              found;
  int                scan_idx;

  assign load_en = ~out_valid | out_ready;
  assign any_gnt = |gnt;
  // rst gates in_ready explicitly: out_valid is 0 during reset, so load_en alone would not
  assign in_ready = gnt & {NUM_CH{load_en & ~rst}};

  // One-hot grant: fixed channel from sel, or first valid channel after rr_ptr
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (!mode) begin
      // Out-of-range sel simply grants nothing
      if (int'(sel) < NUM_CH) begin
        gnt[sel] = in_valid[sel];
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!found && in_valid[SEL_W'(scan_idx)]) begin
          found                    = 1'b1;
          gnt[SEL_W'(scan_idx)] = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant into a channel index and pick that channel's data
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SEL_W'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot and round-robin pointer; a stalled slot holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (any_gnt) begin
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
        if (mode) begin
          rr_ptr <= gnt_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
